// File: rtl/gba_line_cache.sv
// gba_line_cache: four-line GBA pixel ring with a registered 3x3 read window.
// The writer fills lines in raster order; the reader returns the neighbourhood of curPxl on rd_line.
module gba_line_cache #(
    parameter int LINE_W = 240,
    parameter int LINE_H = 160
) (
    input  logic             pxlClk,
    input  logic             rst,
    input  logic             frameStartIn,
    input  logic             pxlInValid,
    input  logic [7:0]       pxlInRed,
    input  logic [7:0]       pxlInGreen,
    input  logic [7:0]       pxlInBlue,
    input  logic             nextLine,
    input  logic             cacheUpdate,
    input  logic [7:0]       curPxl,
    output logic [8:0][23:0] win,
    output logic             sameLine,
    output logic             newFrame,
    output logic             overrun
);
    localparam logic [7:0] X_MAX  = 8'(LINE_W - 1);
    localparam logic [7:0] L_END  = 8'(LINE_H);
    localparam logic [7:0] RD_MAX = 8'(LINE_H - 1);

    logic [23:0]      mem_q [4][LINE_W];
    logic [7:0]       wr_x_q, wr_x_d, wr_line_q, wr_line_d, rd_line_q, rd_line_d;
    logic             frozen_q, frozen_d, new_frame_q, new_frame_d;
    logic             same_line_q, same_line_d, overrun_q, overrun_d;
    logic [8:0][23:0] win_q, win_d;
    logic [7:0]       wx, wl, cx;
    logic [2:0][7:0]  col;
    logic [2:0][1:0]  bank;
    logic             we, line_done, handoff, prev_ok, next_ok;

    always_comb begin
        wx          = frameStartIn ? 8'd0 : wr_x_q;
        wl          = frameStartIn ? 8'd0 : wr_line_q;
        we          = pxlInValid && wl != L_END;
        line_done   = we && wx == X_MAX;
        wr_x_d      = we ? (line_done ? 8'd0 : wx + 8'd1) : wx;
        wr_line_d   = line_done ? wl + 8'd1 : wl;
        handoff     = cacheUpdate && new_frame_q;
        // the writer is about to reuse the bank of the reader's prev line: push the reader forward
        overrun_d   = line_done && !frozen_q && !handoff && wl + 8'd1 == rd_line_q + 8'd4;
        frozen_d    = frameStartIn || (frozen_q && !handoff);
        new_frame_d = (line_done && wl == 8'd1) || (new_frame_q && !handoff);
        rd_line_d   = handoff ? 8'd0 :
                      (overrun_d || (nextLine && !same_line_q)) ? rd_line_q + 8'd1 : rd_line_q;
        same_line_d = frozen_d || wr_line_d < rd_line_d + 8'd2 || rd_line_d == RD_MAX;
        cx          = curPxl > X_MAX ? X_MAX : curPxl;
        col[0]      = cx == 8'd0 ? cx : cx - 8'd1;
        col[1]      = cx;
        col[2]      = cx == X_MAX ? cx : cx + 8'd1;
        prev_ok     = rd_line_q != 8'd0 && !frozen_q && wr_line_q != rd_line_q + 8'd3;
        next_ok     = rd_line_q != RD_MAX && !frozen_q && wr_line_q >= rd_line_q + 8'd2;
        bank[1]     = rd_line_q[1:0];
        bank[0]     = prev_ok ? bank[1] - 2'd1 : bank[1];
        bank[2]     = next_ok ? bank[1] + 2'd1 : bank[1];
    end

    for (genvar r = 0; r < 3; r++) begin : g_r
        for (genvar c = 0; c < 3; c++) begin : g_c
            assign win_d[r*3+c] = mem_q[bank[r]][col[c]];
        end
    end

    always_ff @(posedge pxlClk) begin
        if (we) mem_q[wl[1:0]][wx] <= {pxlInRed, pxlInGreen, pxlInBlue};
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            wr_x_q      <= '0;
            wr_line_q   <= '0;
            rd_line_q   <= '0;
            frozen_q    <= 1'b1;
            new_frame_q <= 1'b0;
            same_line_q <= 1'b1;
            overrun_q   <= 1'b0;
            win_q       <= '0;
        end else begin
            wr_x_q      <= wr_x_d;
            wr_line_q   <= wr_line_d;
            rd_line_q   <= rd_line_d;
            frozen_q    <= frozen_d;
            new_frame_q <= new_frame_d;
            same_line_q <= same_line_d;
            overrun_q   <= overrun_d;
            win_q       <= win_d;
        end
    end

    assign win      = win_q;
    assign sameLine = same_line_q;
    assign newFrame = new_frame_q;
    assign overrun  = overrun_q;
endmodule

// File: doc/gba_line_cache.md
# gba_line_cache

Four-line pixel cache between the GBA capture path and the HDMI image generator. The writer side takes GBA pixels in raster order and stores them in a 4-bank line ring. The reader side is addressed by the image generator (`nextLine`, `cacheUpdate`, `curPxl`). It returns the registered 3x3 neighbourhood around the addressed pixel, plus the `sameLine` and `newFrame` flow-control flags that the generator uses to pace line advance and frame alignment.

## Interface
Parameters:
- `LINE_W`, 240: pixels per GBA line.
- `LINE_H`, 160: lines per GBA frame.

Ports:
- `pxlClk`  in  1  pixel clock; all logic in this domain.
- `rst`  in  1  reset: synchronous, active-high, on `pxlClk`.
- `frameStartIn`  in  1  pulse; the writer begins a new frame.
- `pxlInValid`  in  1  write strobe for one pixel.
- `pxlInRed`, `pxlInGreen`, `pxlInBlue`  in  8 each  pixel data.
- `nextLine`  in  1  pulse; request to advance the read line.
- `cacheUpdate`  in  1  pulse at each HDMI line end; frame handoff point.
- `curPxl`  in  8  read column; values ≥ `LINE_W` are clamped to `LINE_W`-1.
- `win`  out  9x24  window. Index = row*3+col, where row 0/1/2 = prev/cur/next line and col 0/1/2 = prev/cur/next pixel. Each entry is {R,G,B}.
- `sameLine`  out  1  1 = advancing the read line is not permitted.
- `newFrame`  out  1  1 = a new frame is ready and is waiting for the `cacheUpdate` handoff.
- `overrun`  out  1  one-cycle pulse; the writer overtook the reader.

## Operation
- Storage: 4 banks × `LINE_W` × 24 bit. GBA line L is stored in bank L[1:0].
- Writer state: `wrX` (0..239) and `wrLine` (0..160).
  - Each `pxlInValid` writes to bank `wrLine`[1:0] at address `wrX`, then increments `wrX`.
  - At `wrX`==239 the write wraps `wrX` to 0 and increments `wrLine`; line `wrLine` is then complete.
  - Writes are dropped while `wrLine`==160.
  - `frameStartIn` sets `wrX`←0, `wrLine`←0 and `frozen`←1. This takes priority over a same-cycle `pxlInValid`; that pixel is written at x=0 of line 0.
- Reader state: `rdLine` (0..159) and the `frozen` flag.
- `newFrame` ← 1 when the writer completes line 1 (`wrLine` becomes 2).
- Handoff: on `cacheUpdate` with `newFrame`=1, the block sets `rdLine`←0, `frozen`←0 and `newFrame`←0. A same-cycle `nextLine` is ignored.
- `sameLine` = `frozen` OR (`wrLine` < `rdLine`+2) OR (`rdLine`==159).
- `nextLine` with `sameLine`=0 sets `rdLine`←`rdLine`+1. With `sameLine`=1 it is ignored.
- Row validity:
  - The prev row is valid when `rdLine`>0, `frozen`=0 and `wrLine` ≠ `rdLine`+3 (the prev bank is not being rewritten).
  - The next row is valid when `rdLine`<159, `frozen`=0 and `wrLine` ≥ `rdLine`+2.
  - An invalid row is replaced by the cur row.
  - While `frozen`, all three rows come from bank `rdLine`[1:0]. Tearing is accepted.
- Column clamp: col 0 at x=0 and col 2 at x=239 both return the col 1 pixel.
- Overrun: if the writer completes a line while `wrLine`+1 == `rdLine`+4 and `frozen`=0, the block forces `rdLine`←`rdLine`+1 and pulses `overrun`.
  - This forced advance has priority over `nextLine`; there is no double advance in that cycle.

## Timing
- Reset values:
  - Outputs: `win` all 0, `sameLine`=1, `newFrame`=0, `overrun`=0.
  - Internal state: `wrX`=0, `wrLine`=0, `rdLine`=0, `frozen`=1.
- Read latency is 1 cycle. `win` at cycle N+1 reflects `curPxl`, `rdLine` and memory contents at cycle N.
- A `rdLine` change takes effect for `curPxl` sampled in the cycle after `nextLine` or the handoff.
- Write-to-read: a pixel written at cycle N is readable at cycle N+1. A same-address read at cycle N returns the old data.
- `sameLine` and `newFrame` are registered and update 1 cycle after the causing event.
- A `rst` asserted mid-frame discards all state. Bank contents are not cleared, but rows are unused until the next handoff.

## Test plan
- After reset, feed 2 lines of pixels with value x + 256·line, then pulse `cacheUpdate` -> `newFrame` rises after the 480th pixel and clears after the handoff; `rdLine`=0; `curPxl`=5 gives `win`[4]=0x000005, `win`[7]=0x000105, and `win`[1]=`win`[4] (prev row clamped).
- `curPxl`=0 and `curPxl`=250 -> `win`[3]==`win`[4] and `win`[5]==`win`[4] respectively; col 0 and col 2 clamp correctly at both edges.
- With `wrLine`=2 and `rdLine`=0: `sameLine`=0; pulse `nextLine` -> `rdLine`=1, `sameLine`=1, and the next row is clamped to the cur row until line 2 completes.
- Let the writer run 4 lines ahead without any `nextLine` -> `overrun` is a single-cycle pulse and `rdLine` increments by exactly 1.
- Assert `frameStartIn` mid-read -> `sameLine`=1, `nextLine` is ignored and all rows equal the cur row until the handoff after line 1 of the new frame.
- Assert `rst` during writing -> all outputs return to their reset values in the next cycle.
